// File: rtl/spi_ram_master_ctrl_if.sv
// Request/response and SPI pin bundle for spi_ram_master_ctrl.
// The modport names follow the request port. "master" is the host side, which drives
// requests and also supplies MISO. "slave" is the controller, which accepts requests
// and drives the SPI select and data lines.
interface spi_ram_master_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       done;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       ss_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, MISO,
        input  req_ready, done, rsp_rdata, busy, ss_n, MOSI
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, MISO,
        output req_ready, done, rsp_rdata, busy, ss_n, MOSI
    );
endinterface

// File: rtl/spi_ram_master_ctrl.sv
// Host-side SPI master that runs the two-frame sequence needed to write or read one byte
// of the SPI-slave RAM. The sequence is an address frame followed by a data frame.
// Each frame is an 11-bit word {sel, cmd[1:0], payload} shifted out MSB first, after
// a single START cycle. A read-data frame keeps ss_n low through MISO_LAT wait cycles
// and then 8 sample cycles. Every frame is followed by GAP_CYCLES cycles with ss_n high.
module spi_ram_master_ctrl #(
    parameter int MISO_LAT   = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_ram_master_ctrl_if.slave bus
);
    // One counter is shared by all timed states. It is sized for the longest of them.
    localparam int CNT_MAX = (MISO_LAT > GAP_CYCLES)
                           ? ((MISO_LAT > 10) ? MISO_LAT : 10)
                           : ((GAP_CYCLES > 10) ? GAP_CYCLES : 10);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(10);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'((MISO_LAT > 0) ? MISO_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_WAIT,
        S_SAMPLE,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;   // low until the first clock edge after reset
    logic             op_q;
    logic             frame2;    // set once the first frame and its gap are finished
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       shift_q;
    logic [7:0]       rdata_q;
    logic             accept;
    logic [10:0]      frame;
    logic [3:0]       bit_idx;

    // The frame word currently being sent: the address frame first, then the data frame.
    always_comb begin
        if (!op_q)
            frame = frame2 ? {3'b001, wdata_q} : {3'b000, addr_q};
        else
            frame = frame2 ? {3'b111, 8'h00} : {3'b110, addr_q};
    end

    assign bit_idx       = 4'd10 - cnt[3:0];
    assign bus.rsp_rdata = rdata_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops are written with <= so every register samples pre-edge values
        // regardless of block ordering.
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Next-state decode and pin outputs.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d       = state;
        accept        = 1'b0;
        bus.req_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.ss_n      = 1'b0;
        bus.MOSI      = 1'b0;
        bus.done      = 1'b0;
        case (state)
            S_IDLE: begin
                bus.busy      = 1'b0;
                bus.ss_n      = 1'b1;
                bus.req_ready = ready_q & ~rst;
                if (bus.req_valid && ready_q && !rst) begin
                    accept  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_BITS;
            S_BITS: begin
                bus.MOSI = frame[bit_idx];
                if (cnt == BIT_LAST) begin
                    if (frame2 && op_q)
                        state_d = (MISO_LAT == 0) ? S_SAMPLE : S_WAIT;
                    else
                        state_d = S_GAP;
                end
            end
            S_WAIT: begin
                if (cnt == WAIT_LAST)
                    state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (cnt == SAMPLE_LAST)
                    state_d = S_GAP;
            end
            S_GAP: begin
                bus.ss_n = 1'b1;
                bus.done = frame2 && (cnt == '0);
                if (cnt == GAP_LAST)
                    state_d = frame2 ? S_IDLE : S_START;
            end
            default: begin
                state_d  = S_IDLE;
                bus.busy = 1'b0;
                bus.ss_n = 1'b1;
            end
        endcase
    end

    // Request capture, the shared state counter, frame tracking and MISO shift-in.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath is reset with the FSM, so an aborted transfer leaves nothing stale and no X can reach MOSI or rsp_rdata.
        if (rst) begin
            cnt     <= '0;
            ready_q <= 1'b0;
            op_q    <= 1'b0;
            frame2  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b1;
            if (state_d != state || state == S_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                frame2  <= 1'b0;
            end else if (state == S_GAP && state_d == S_START) begin
                frame2 <= 1'b1;
            end

            if (state == S_SAMPLE) begin
                shift_q <= {shift_q[6:0], bus.MISO};
                if (cnt == SAMPLE_LAST)
                    rdata_q <= {shift_q[6:0], bus.MISO};
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Self-checking bench for spi_ram_master_ctrl.
// The bench acts as both the host and the SPI-slave RAM. It keeps a byte array as the RAM
// image and predicts pin activity from transaction offsets counted from the accept edge.
// Completed responses are queued in a scoreboard, and a monitor pops the queue each time
// done pulses.
module tb_spi_ram_master_ctrl;
    localparam int L       = 2;
    localparam int G       = 2;
    localparam int DONE_W  = 25 + G;
    localparam int DONE_R  = 33 + G + L;
    localparam int READY_W = 25 + 2 * G;
    localparam int READY_R = 33 + 2 * G + L;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_ram_master_ctrl_if bus ();

    spi_ram_master_ctrl #(
        .MISO_LAT  (L),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         done_cyc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] mem[256];
    int         cyc = 0;
    bit         clean = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         finished = 1'b0;
    logic [7:0] last_rdata = 8'h00;
    int         miso_off;

    // The transaction in flight, as seen by the model.
    bit         cur_valid = 1'b0;
    logic       cur_op = 1'b0;
    logic [7:0] cur_addr = 8'h00;
    logic [7:0] cur_wdata = 8'h00;
    logic [7:0] cur_rdata = 8'h00;
    int         cur_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_word(input logic op, input bit second,
                                               input logic [7:0] addr, input logic [7:0] wdata);
        if (!op)
            return second ? {3'b001, wdata} : {3'b000, addr};
        else
            return second ? {3'b111, 8'h00} : {3'b110, addr};
    endfunction

    // Expected {req_ready, busy, ss_n, MOSI} for the cycle at offset 'off' from the accept.
    // Offset 1 is the cycle right after the accept edge.
    function automatic logic [3:0] exp_pins(input int off);
        int         r;
        logic       ss;
        logic       mosi;
        logic [10:0] f;
        r = cur_op ? READY_R : READY_W;
        if (rst)
            return 4'b0010;
        if (!cur_valid || off < 1 || off >= r)
            return {clean, 1'b0, 1'b1, 1'b0};
        ss   = 1'b1;
        mosi = 1'b0;
        if (off <= 12) begin
            ss = 1'b0;
            f  = frame_word(cur_op, 1'b0, cur_addr, cur_wdata);
            if (off >= 2)
                mosi = f[12 - off];
        end else if (off >= 13 + G && off <= 24 + G) begin
            ss = 1'b0;
            f  = frame_word(cur_op, 1'b1, cur_addr, cur_wdata);
            if (off >= 14 + G)
                mosi = f[24 + G - off];
        end else if (cur_op && off >= 25 + G && off <= 32 + G + L) begin
            ss = 1'b0;
        end
        return {1'b0, 1'b1, ss, mosi};
    endfunction

    // Cycle counter, plus a record of whether a clock edge has passed since reset was released.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        clean <= !rst;
    end

    // Slave side: present the stored byte MSB first during the sample window, noise otherwise.
    always @(posedge clk) begin
        #1;
        miso_off = cyc - cur_a + 1;
        if (cur_valid && cur_op && !rst && miso_off >= 25 + G + L && miso_off <= 32 + G + L)
            bus.MISO = cur_rdata[7 - (miso_off - 25 - G - L)];
        else
            bus.MISO = 1'($urandom_range(0, 1));
    end

    // Per-cycle pin check against the timing model.
    always @(negedge clk) begin
        if (!finished)
            check("pins{ready,busy,ss_n,mosi}",
                  32'({bus.req_ready, bus.busy, bus.ss_n, bus.MOSI}),
                  32'(exp_pins(cyc - cur_a + 1)));
    end

    // Scoreboard monitor: each done pulse must match the oldest outstanding transaction.
    always @(negedge clk) begin
        if (!finished && bus.done) begin
            if (rst || sb_q.size() == 0) begin
                check("done_while_idle", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                if (mon_e.op)
                    last_rdata = mon_e.rdata;
                check(mon_e.op ? "rsp_rdata_read" : "rsp_rdata_held",
                      32'(bus.rsp_rdata), 32'(last_rdata));
            end
        end
    end

    // Present one request. Called at posedge+1, and returns at posedge+1 after the accept edge.
    // With keep set, req_valid stays high afterwards (with scrambled fields) so the next call
    // starts immediately.
    task automatic issue(input logic op, input logic [7:0] addr, input logic [7:0] wdata,
                         input bit keep);
        int waited;
        waited        = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        forever begin
            @(negedge clk);
            if (!rst && bus.req_ready)
                break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 32'(bus.req_ready), 32'd1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        cur_a     = cyc + 1;
        cur_op    = op;
        cur_addr  = addr;
        cur_wdata = wdata;
        cur_rdata = mem[addr];
        cur_valid = 1'b1;
        sb_q.push_back('{op, addr, wdata, mem[addr], cur_a + (op ? DONE_R : DONE_W) - 1});
        if (!op)
            mem[addr] = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = keep;
        bus.req_op    = 1'($urandom_range(0, 1));
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 8'($urandom);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.MISO      = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed write and read-back of the same byte, then a held-valid back-to-back pair.
        issue(1'b0, 8'h3C, 8'hA5, 1'b0);
        issue(1'b1, 8'h3C, 8'h00, 1'b0);
        issue(1'b0, 8'h7F, 8'hFF, 1'b1);
        issue(1'b1, 8'h7F, 8'h00, 1'b0);

        // Reset in the middle of the first frame of a read: the read is aborted with no done.
        issue(1'b1, 8'h3C, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst        = 1'b1;
        cur_valid  = 1'b0;
        sb_q.delete();
        last_rdata = 8'h00;
        #1;
        check("reset_immediate{ss_n,mosi,done,busy,ready,rdata}",
              32'({bus.ss_n, bus.MOSI, bus.done, bus.busy, bus.req_ready, bus.rsp_rdata}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic over a small address window so that reads hit earlier writes.
        for (int i = 0; i < 40; i++) begin
            logic       op;
            logic [7:0] addr;
            bit         keep;
            op   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            keep = (i != 39) && ($urandom_range(0, 1) == 1);
            issue(op, addr, 8'($urandom), keep);
            if (!keep && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 50)) @(posedge clk);
                #1;
            end
        end

        for (int w = 0; w < 200 && sb_q.size() != 0; w++)
            @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (G + 2) @(negedge clk);
        finished = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
